noc_sink: RTL

Ejection-side receiver attached to one output port of the 2x2 `noc` mesh. It registers each delivered 16-bit flit and checks its destination mask and per-source sequence number. Accepted flits are buffered in a show-ahead FIFO for the local processing element. Back-pressure uses the same `full`/`almost_full` contract the `cpu` traffic generators already obey.

---
 rtl/noc_sink.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/noc_sink.sv
// -----------------------------------------------------------------------------
// noc_sink
//
// Receiver on the ejection side of one output port of the 2x2 mesh. It handles
// each delivered 16-bit flit in three steps:
//   S0: latches the flit into a staging register.
//   S1: checks the destination mask and, optionally, the per-source sequence
//       number.
//   FIFO: accepted flits are pushed into a show-ahead FIFO for the local PE.
//
// Flit layout: seq[15:7], src[6:5], dest[4:1], valid[0].
//
// Optional feature: define NOC_SINK_SEQCHK_EN to build the per-source
// expected-sequence table and the seq_err/err_src logic. Without the macro,
// both outputs are tied to zero.
//
// Parameters:
//   ID     node index 0..3; selects the dest-mask bit that this sink owns.
//   DEPTH  FIFO entries; must be a power of two and at least 4.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   write        flit strobe from the NoC output port
//   dataIn       incoming flit
//   full         no slot free (staged flit counts as occupied)
//   almost_full  at most one slot free
//   read         pop request from the PE
//   dataOut      head flit; valid while empty = 0
//   empty        FIFO holds no flit
//   clear_err    synchronous clear of the sticky flags
//   seq_err      sticky: sequence mismatch seen
//   err_src      src of the most recent mismatching flit
//   misroute     sticky: flit arrived with dest[ID] = 0
//   overflow     sticky: write arrived while full
//   rx_count     flits enqueued, modulo 2^16
// -----------------------------------------------------------------------------
module noc_sink #(
    parameter int unsigned ID    = 0,
    parameter int unsigned DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        write,
    input  logic [15:0] dataIn,
    output logic        full,
    output logic        almost_full,
    input  logic        read,
    output logic [15:0] dataOut,
    output logic        empty,
    input  logic        clear_err,
    output logic        seq_err,
    output logic [1:0]  err_src,
    output logic        misroute,
    output logic        overflow,
    output logic [15:0] rx_count
);

    localparam int unsigned   AW         = $clog2(DEPTH);
    localparam int unsigned   CW         = AW + 1;
    localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
    localparam logic [CW-1:0] DEPTH_M1_C = CW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_ONE    = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0] PTR_ONE    = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [1:0]    ID_C       = 2'(ID);

    // S0 staging register
    logic [15:0]   stg_q, stg_d;
    logic          stg_v_q, stg_v_d;

    // FIFO storage and bookkeeping
    logic [15:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] occ;

    // Sticky flags and counter
    logic          misroute_q, misroute_d;
    logic          overflow_q, overflow_d;
    logic [15:0]   rx_count_q, rx_count_d;

    // Per-cycle events
    logic [3:0]    stg_dest;
    logic          dest_hit;
    logic          accept;
    logic          push;
    logic          pop;
    logic          misroute_ev;
    logic          overflow_ev;

    // The staged flit counts toward occupancy. This keeps full/almost_full
    // purely registered while still reserving its slot.
    assign occ         = cnt_q + {{(CW-1){1'b0}}, stg_v_q};
    assign full        = (occ == DEPTH_C);
    assign almost_full = (occ >= DEPTH_M1_C);
    assign empty       = (cnt_q == {CW{1'b0}});
    assign dataOut     = mem_q[rd_ptr_q];

    assign stg_dest    = stg_q[4:1];
    assign dest_hit    = stg_dest[ID_C];
    assign accept      = write & ~full & dataIn[0];
    assign push        = stg_v_q & dest_hit;
    assign misroute_ev = stg_v_q & ~dest_hit;
    assign overflow_ev = write & full;
    assign pop         = read & ~empty;

    // Next-state logic for the staging register
    always_comb begin
        stg_v_d = accept;
        if (accept) begin
            stg_d = dataIn;
        end else begin
            stg_d = stg_q;
        end
    end

    // Staging register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stg_q   <= 16'h0000;
            stg_v_q <= 1'b0;
        end else begin
            stg_q   <= stg_d;
            stg_v_q <= stg_v_d;
        end
    end

    // FIFO storage; reset to zero so dataOut reads 0 out of reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= 16'h0000;
            end
        end else if (push) begin
            mem_q[wr_ptr_q] <= stg_q;
        end
    end

    // Next-state logic for pointers, count, flags and rx counter
    always_comb begin
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase
        if (push) begin
            rx_count_d = rx_count_q + 16'd1;
        end else begin
            rx_count_d = rx_count_q;
        end
        // A new event wins over a simultaneous clear
        misroute_d = misroute_ev | (misroute_q & ~clear_err);
        overflow_d = overflow_ev | (overflow_q & ~clear_err);
    end

    // Pointer, count, flag and counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= {AW{1'b0}};
            rd_ptr_q   <= {AW{1'b0}};
            cnt_q      <= {CW{1'b0}};
            rx_count_q <= 16'h0000;
            misroute_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            rx_count_q <= rx_count_d;
            misroute_q <= misroute_d;
            overflow_q <= overflow_d;
        end
    end

    assign misroute = misroute_q;
    assign overflow = overflow_q;
    assign rx_count = rx_count_q;

`ifdef NOC_SINK_SEQCHK_EN
    logic [8:0] exp_q [4];
    logic [8:0] stg_seq;
    logic [1:0] stg_src;
    logic [8:0] exp_cur;
    logic [8:0] seq_nxt;
    logic       mismatch;
    logic       seq_err_q, seq_err_d;
    logic [1:0] err_src_q, err_src_d;

    assign stg_seq = stg_q[15:7];
    assign stg_src = stg_q[6:5];

    // Sequence compare. Only flits that are actually enqueued are checked.
    always_comb begin
        exp_cur   = exp_q[stg_src];
        seq_nxt   = stg_seq + 9'd1;
        mismatch  = push & (stg_seq != exp_cur);
        seq_err_d = mismatch | (seq_err_q & ~clear_err);
        if (mismatch) begin
            err_src_d = stg_src;
        end else begin
            err_src_d = err_src_q;
        end
    end

    // Expected-sequence table. It always resynchronises to seq+1 on enqueue.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                exp_q[i] <= 9'd0;
            end
            seq_err_q <= 1'b0;
            err_src_q <= 2'b00;
        end else begin
            if (push) begin
                exp_q[stg_src] <= seq_nxt;
            end
            seq_err_q <= seq_err_d;
            err_src_q <= err_src_d;
        end
    end

    assign seq_err = seq_err_q;
    assign err_src = err_src_q;
`else
    assign seq_err = 1'b0;
    assign err_src = 2'b00;
`endif

endmodule
